ddr2_init_sequencer: RTL and testbench
======================================

Name: ddr2_init_sequencer

Overview:
- Registered command sequencer that runs the JEDEC DDR2 power-up and initialization sequence.
- Drives the command, address and control inputs of the SSTL18 DDR2 pad interface: cke, csbar, rasbar, casbar, webar, ba, a, odt, ts, ri.
- Starts automatically when reset is released and asserts init_done when the sequence is complete.
- The main controller owns the pads only after init_done is asserted.

Parameters:
- T_INIT, 26667: cycles CKE held low after reset release (200 us at 133 MHz).
- T_XPR, 54: cycles from CKE high to the first PRECHARGE ALL.
- T_RP, 3: cycles from PRECHARGE to the next command.
- T_MRD, 2: cycles from a mode-register load to the next command.
- T_RFC, 14: cycles from REFRESH to the next command.
- T_DLLK, 200: minimum cycles from the DLL-reset MR load to init_done.
- CL, 3: CAS latency, written to MR a[6:4].
- BL8, 0: 1 selects BL8 (MR a[2:0]=011); 0 selects BL4 (010).
- WR, 3: write recovery, written to MR a[11:9] as WR-1.
- AL, 0: additive latency, written to EMR1 a[5:3].
- RTT, 2'b00: ODT value, written to EMR1 {a6,a2}.

Ports:
- clk, input, 1: system clock, same clock that drives ck_i.
- resetbar, input, 1: asynchronous active-low reset.
- cke_o, output, 1: to cke_i.
- csbar_o, output, 1: to csbar_i.
- rasbar_o, output, 1: to rasbar_i.
- casbar_o, output, 1: to casbar_i.
- webar_o, output, 1: to webar_i.
- ba_o, output, 2: to ba_i.
- a_o, output, 13: to a_i.
- odt_o, output, 1: to odt_i.
- ts_o, output, 1: DQ/DQS drive enable; 0 for the whole sequence.
- ri_o, output, 1: DQ receive enable; 0 for the whole sequence.
- init_done, output, 1: sticky high once initialization is complete.

Behaviour:
- Reset is asynchronous and active-low.
- Reset values: cke_o=0, csbar_o=0, rasbar_o=1, casbar_o=1, webar_o=1 (NOP), ba_o=0, a_o=0, odt_o=0, ts_o=0, ri_o=0, init_done=0. State is RESET_WAIT.
- All outputs are registered.
- Each command is driven for exactly one cycle, with NOP in every other cycle.
- Command encodings {rasbar,casbar,webar}, with csbar=0:
  - NOP = 111.
  - PRECHARGE ALL = 010, with a[10]=1.
  - REFRESH = 001.
  - Mode-register load = 000, with ba selecting MR=00, EMR1=01, EMR2=10, EMR3=11.
- Cycle numbering: cycle 0 is the first rising edge with resetbar high.
- A wait counter of at least 16 bits is loaded on each transition. The next command issues exactly T cycles after the previous one, where T is the applicable wait.
- Sequence (state: action, then wait before the next step):
  1. RESET_WAIT: CKE low, wait T_INIT.
  2. CKE_HIGH: cke_o=1 at cycle T_INIT; it stays 1 forever after. Wait T_XPR.
  3. PRE1: wait T_RP.
  4. EMR2: a=0. Wait T_MRD.
  5. EMR3: a=0. Wait T_MRD.
  6. EMR1_DLL: DLL enable, a0=0, AL, RTT, OCD=000. Wait T_MRD.
  7. MR_DLLRST: a8=1, plus BL, CL, WR. Starts the DLL counter. Wait T_MRD.
  8. PRE2: wait T_RP.
  9. REF1: wait T_RFC.
  10. REF2: wait T_RFC.
  11. MR: a8=0. Wait T_MRD.
  12. EMR1_OCDDEF: a[9:7]=111. Wait T_MRD.
  13. EMR1_OCDEXIT: a[9:7]=000. Wait T_MRD.
  14. DLL_WAIT: holds NOP until the DLL counter reaches T_DLLK.
  15. DONE.
- DLL counter: saturates at T_DLLK.
- init_done rises at cycle max(T_INIT+T_XPR+2*T_RP+7*T_MRD+2*T_RFC, T_INIT+T_XPR+T_RP+3*T_MRD+T_DLLK).
- DONE state: outputs hold NOP with cke_o=1; no further commands; init_done stays 1.
- Address bits not listed for a command are 0. a_o and ba_o return to 0 on NOP cycles.
- resetbar low at any point, including mid-sequence or in DONE, immediately forces the reset values. The sequence then restarts from RESET_WAIT, with the full T_INIT re-counted.
- A wait parameter of 0 is illegal; every wait is at least 1.
- odt_o, ts_o and ri_o are never asserted by this block.

Test Plan:
Directed tests use T_INIT=10, T_XPR=4, T_RP=3, T_MRD=2, T_RFC=8, T_DLLK=20, CL=3, BL8=0, WR=3, AL=0, RTT=00.
1. Release reset -> cke_o=0 through cycle 9 and 1 from cycle 10. PRECHARGE ALL at cycle 14 with a_o=13'h0400. NOP on all other cycles 0-16.
2. Full sequence -> commands issue at exactly these cycles:
   - EMR2 at 17 (ba=10).
   - EMR3 at 19 (ba=11).
   - EMR1 at 21 (ba=01, a=0).
   - MR at 23 (ba=00, a=13'h0532).
   - PRE at 25.
   - REF at 28 and 36.
   - MR at 44 (a=13'h0432).
   - EMR1 at 46 (a=13'h0380).
   - EMR1 at 48 (a=0).
   - init_done=1 at cycle 50.
3. T_DLLK=40 -> init_done rises at cycle 63, not 50. NOP on cycles 49-62.
4. BL8=1, AL=2, RTT=01 -> MR a_o=13'h0533. EMR1 DLL-enable a_o=13'h0014. EMR1 OCD-default a_o=13'h0394.
5. resetbar pulsed low at cycle 30 (mid-refresh) -> outputs at reset values immediately (cke_o=0). After release, cke_o rises 10 cycles later and the full command sequence repeats. No stale REF is issued.
6. After init_done, run 1000 cycles -> init_done stays 1, NOP held, cke_o=1, ts_o=ri_o=odt_o=0 throughout.

Source files
------------

// File: rtl/ddr2_init_sequencer.sv
// DDR2 power-up/initialization command sequencer driving the SSTL18 pad
// command, address and control inputs until init_done hands the pads over.
module ddr2_init_sequencer #(
   parameter int unsigned T_INIT = 26667,
   parameter int unsigned T_XPR  = 54,
   parameter int unsigned T_RP   = 3,
   parameter int unsigned T_MRD  = 2,
   parameter int unsigned T_RFC  = 14,
   parameter int unsigned T_DLLK = 200,
   parameter int unsigned CL     = 3,
   parameter int unsigned BL8    = 0,
   parameter int unsigned WR     = 3,
   parameter int unsigned AL     = 0,
   parameter logic [1:0]  RTT    = 2'b00
) (
   input  logic        clk,
   input  logic        resetbar,
   output logic        cke_o,
   output logic        csbar_o,
   output logic        rasbar_o,
   output logic        casbar_o,
   output logic        webar_o,
   output logic [1:0]  ba_o,
   output logic [12:0] a_o,
   output logic        odt_o,
   output logic        ts_o,
   output logic        ri_o,
   output logic        init_done
);

   localparam int unsigned CNT_W = 16;
   localparam int unsigned A_W   = 13;

   // Wait reloads are T-1 so the next command lands exactly T cycles later
   localparam logic [CNT_W-1:0] INIT_C = CNT_W'(T_INIT);
   localparam logic [CNT_W-1:0] XPR_C  = CNT_W'(T_XPR - 1);
   localparam logic [CNT_W-1:0] RP_C   = CNT_W'(T_RP - 1);
   localparam logic [CNT_W-1:0] MRD_C  = CNT_W'(T_MRD - 1);
   localparam logic [CNT_W-1:0] RFC_C  = CNT_W'(T_RFC - 1);
   localparam logic [CNT_W-1:0] DLLK_C = CNT_W'(T_DLLK);

   // {rasbar, casbar, webar}; csbar is held low throughout
   localparam logic [2:0] CMD_NOP = 3'b111;
   localparam logic [2:0] CMD_PRE = 3'b010;
   localparam logic [2:0] CMD_REF = 3'b001;
   localparam logic [2:0] CMD_MRS = 3'b000;

   localparam logic [1:0] BA_MR   = 2'b00;
   localparam logic [1:0] BA_EMR1 = 2'b01;
   localparam logic [1:0] BA_EMR2 = 2'b10;
   localparam logic [1:0] BA_EMR3 = 2'b11;

   // MR: a[11:9]=WR-1, a8=DLL reset, a[6:4]=CL, a3=sequential, a[2:0]=BL
   localparam logic [A_W-1:0] A_PRE_ALL   = 13'h0400;
   localparam logic [A_W-1:0] A_MR        = {1'b0, 3'(WR - 1), 1'b0, 1'b0, 3'(CL), 1'b0,
                                             (BL8 != 0) ? 3'b011 : 3'b010};
   localparam logic [A_W-1:0] A_MR_DLLRST = A_MR | 13'h0100;
   // EMR1: a6/a2=RTT, a[5:3]=AL, a0=0 enables the DLL, a[9:7]=OCD
   localparam logic [A_W-1:0] A_EMR1      = {3'b000, 3'b000, RTT[1], 3'(AL), RTT[0], 2'b00};
   localparam logic [A_W-1:0] A_EMR1_OCD  = A_EMR1 | 13'h0380;

   typedef enum logic [3:0] {
      S_RESET_WAIT, S_CKE_HIGH, S_PRE1, S_EMR2, S_EMR3, S_EMR1_DLL, S_MR_DLLRST,
      S_PRE2, S_REF1, S_REF2, S_MR, S_EMR1_OCDDEF, S_EMR1_OCDEXIT, S_DLL_WAIT, S_DONE
   } state_e;

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] dll_q;
   logic             cke_q;
   logic [2:0]       cmd_q;
   logic [1:0]       ba_q;
   logic [A_W-1:0]   a_q;
   logic             init_done_q;
   logic             wait_over_c;

   // Current step's wait has elapsed; the next step fires on this edge
   assign wait_over_c = (cnt_q == '0);

   // Sequencer: state, wait counter, DLL lock counter and registered pad outputs
   always_ff @(posedge clk or negedge resetbar) begin
      if (!resetbar) begin
         state_q     <= S_RESET_WAIT;
         cnt_q       <= INIT_C;
         dll_q       <= '0;
         cke_q       <= 1'b0;
         cmd_q       <= CMD_NOP;
         ba_q        <= '0;
         a_q         <= '0;
         init_done_q <= 1'b0;
      end else begin
         cmd_q <= CMD_NOP;
         ba_q  <= '0;
         a_q   <= '0;
         if (!wait_over_c) cnt_q <= cnt_q - CNT_W'(1);
         if ((dll_q != '0) && (dll_q != DLLK_C)) dll_q <= dll_q + CNT_W'(1);
         case (state_q)
            S_RESET_WAIT: if (wait_over_c) begin
               state_q <= S_CKE_HIGH; cke_q <= 1'b1; cnt_q <= XPR_C;
            end
            S_CKE_HIGH: if (wait_over_c) begin
               state_q <= S_PRE1; cmd_q <= CMD_PRE; a_q <= A_PRE_ALL; cnt_q <= RP_C;
            end
            S_PRE1: if (wait_over_c) begin
               state_q <= S_EMR2; cmd_q <= CMD_MRS; ba_q <= BA_EMR2; cnt_q <= MRD_C;
            end
            S_EMR2: if (wait_over_c) begin
               state_q <= S_EMR3; cmd_q <= CMD_MRS; ba_q <= BA_EMR3; cnt_q <= MRD_C;
            end
            S_EMR3: if (wait_over_c) begin
               state_q <= S_EMR1_DLL; cmd_q <= CMD_MRS; ba_q <= BA_EMR1; a_q <= A_EMR1;
               cnt_q <= MRD_C;
            end
            S_EMR1_DLL: if (wait_over_c) begin
               state_q <= S_MR_DLLRST; cmd_q <= CMD_MRS; ba_q <= BA_MR; a_q <= A_MR_DLLRST;
               cnt_q <= MRD_C; dll_q <= CNT_W'(1);
            end
            S_MR_DLLRST: if (wait_over_c) begin
               state_q <= S_PRE2; cmd_q <= CMD_PRE; a_q <= A_PRE_ALL; cnt_q <= RP_C;
            end
            S_PRE2: if (wait_over_c) begin
               state_q <= S_REF1; cmd_q <= CMD_REF; cnt_q <= RFC_C;
            end
            S_REF1: if (wait_over_c) begin
               state_q <= S_REF2; cmd_q <= CMD_REF; cnt_q <= RFC_C;
            end
            S_REF2: if (wait_over_c) begin
               state_q <= S_MR; cmd_q <= CMD_MRS; ba_q <= BA_MR; a_q <= A_MR; cnt_q <= MRD_C;
            end
            S_MR: if (wait_over_c) begin
               state_q <= S_EMR1_OCDDEF; cmd_q <= CMD_MRS; ba_q <= BA_EMR1; a_q <= A_EMR1_OCD;
               cnt_q <= MRD_C;
            end
            S_EMR1_OCDDEF: if (wait_over_c) begin
               state_q <= S_EMR1_OCDEXIT; cmd_q <= CMD_MRS; ba_q <= BA_EMR1; a_q <= A_EMR1;
               cnt_q <= MRD_C;
            end
            S_EMR1_OCDEXIT: if (wait_over_c) begin
               if (dll_q == DLLK_C) begin
                  state_q <= S_DONE; init_done_q <= 1'b1;
               end else begin
                  state_q <= S_DLL_WAIT;
               end
            end
            S_DLL_WAIT: if (dll_q == DLLK_C) begin
               state_q <= S_DONE; init_done_q <= 1'b1;
            end
            S_DONE: ;
            default: state_q <= S_RESET_WAIT;
         endcase
      end
   end

   assign cke_o     = cke_q;
   assign csbar_o   = 1'b0;
   assign rasbar_o  = cmd_q[2];
   assign casbar_o  = cmd_q[1];
   assign webar_o   = cmd_q[0];
   assign ba_o      = ba_q;
   assign a_o       = a_q;
   assign odt_o     = 1'b0;
   assign ts_o      = 1'b0;
   assign ri_o      = 1'b0;
   assign init_done = init_done_q;

endmodule

// File: tb/tb_ddr2_init_sequencer.sv
// Directed bench for ddr2_init_sequencer: three instances (default timing,
// long DLL lock, BL8/AL/RTT mode bits) run side by side from a shared reset.
module tb_ddr2_init_sequencer;

   logic        clk;
   logic        resetbar;
   logic        cke   [3];
   logic        csbar [3];
   logic        ras   [3];
   logic        cas   [3];
   logic        we    [3];
   logic        odt   [3];
   logic        ts    [3];
   logic        ri    [3];
   logic        done  [3];
   logic [1:0]  ba    [3];
   logic [12:0] a     [3];

   int checks;
   int errors;
   int cyc;

   ddr2_init_sequencer #(.T_INIT(10), .T_XPR(4), .T_RP(3), .T_MRD(2), .T_RFC(8), .T_DLLK(20))
   u0 (.clk(clk), .resetbar(resetbar), .cke_o(cke[0]), .csbar_o(csbar[0]), .rasbar_o(ras[0]),
       .casbar_o(cas[0]), .webar_o(we[0]), .ba_o(ba[0]), .a_o(a[0]), .odt_o(odt[0]),
       .ts_o(ts[0]), .ri_o(ri[0]), .init_done(done[0]));

   ddr2_init_sequencer #(.T_INIT(10), .T_XPR(4), .T_RP(3), .T_MRD(2), .T_RFC(8), .T_DLLK(40))
   u1 (.clk(clk), .resetbar(resetbar), .cke_o(cke[1]), .csbar_o(csbar[1]), .rasbar_o(ras[1]),
       .casbar_o(cas[1]), .webar_o(we[1]), .ba_o(ba[1]), .a_o(a[1]), .odt_o(odt[1]),
       .ts_o(ts[1]), .ri_o(ri[1]), .init_done(done[1]));

   ddr2_init_sequencer #(.T_INIT(10), .T_XPR(4), .T_RP(3), .T_MRD(2), .T_RFC(8), .T_DLLK(20),
                         .BL8(1), .AL(2), .RTT(2'b01))
   u2 (.clk(clk), .resetbar(resetbar), .cke_o(cke[2]), .csbar_o(csbar[2]), .rasbar_o(ras[2]),
       .casbar_o(cas[2]), .webar_o(we[2]), .ba_o(ba[2]), .a_o(a[2]), .odt_o(odt[2]),
       .ts_o(ts[2]), .ri_o(ri[2]), .init_done(done[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hand-computed command schedule: {rasbar,casbar,webar, ba, a} at cycle c
   function automatic logic [17:0] exp_word(input int sel, input int c);
      logic [17:0] w;
      w = {3'b111, 2'b00, 13'h0000};
      case (c)
         14, 25: w = {3'b010, 2'b00, 13'h0400};
         17:     w = {3'b000, 2'b10, 13'h0000};
         19:     w = {3'b000, 2'b11, 13'h0000};
         21:     w = {3'b000, 2'b01, (sel == 2) ? 13'h0014 : 13'h0000};
         23:     w = {3'b000, 2'b00, (sel == 2) ? 13'h0533 : 13'h0532};
         28, 36: w = {3'b001, 2'b00, 13'h0000};
         44:     w = {3'b000, 2'b00, (sel == 2) ? 13'h0433 : 13'h0432};
         46:     w = {3'b000, 2'b01, (sel == 2) ? 13'h0394 : 13'h0380};
         48:     w = {3'b000, 2'b01, (sel == 2) ? 13'h0014 : 13'h0000};
         default: ;
      endcase
      return w;
   endfunction

   function automatic logic [17:0] obs_word(input int sel);
      return {ras[sel], cas[sel], we[sel], ba[sel], a[sel]};
   endfunction

   function automatic int done_cycle(input int sel);
      return (sel == 1) ? 63 : 50;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic release_reset();
      @(negedge clk);
      resetbar = 1'b1;
      cyc = -1;
   endtask

   task automatic test_reset();
      resetbar = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      for (int s = 0; s < 3; s++) begin
         checks++;
         if ({cke[s], csbar[s], obs_word(s), odt[s], ts[s], ri[s], done[s]} !==
             {1'b0, 1'b0, 3'b111, 2'b00, 13'h0, 4'b0000}) begin
            errors++;
            $display("FAIL reset inst%0d: cke=%b cs=%b cmd=%h odt/ts/ri/done=%b%b%b%b", s,
                     cke[s], csbar[s], obs_word(s), odt[s], ts[s], ri[s], done[s]);
         end
      end
      release_reset();
   endtask

   task automatic test_power_up();
      for (int c = 0; c <= 16; c++) begin
         step();
         for (int s = 0; s < 3; s++) begin
            checks++;
            if (cke[s] !== (c >= 10)) begin
               errors++;
               $display("FAIL cke inst%0d cycle %0d: got %b expected %b", s, cyc, cke[s], c >= 10);
            end
            checks++;
            if ({csbar[s], obs_word(s)} !== {1'b0, exp_word(s, c)}) begin
               errors++;
               $display("FAIL power_up_cmd inst%0d cycle %0d: got %h expected %h", s, cyc,
                        {csbar[s], obs_word(s)}, {1'b0, exp_word(s, c)});
            end
         end
      end
   endtask

   task automatic test_command_schedule(input int first, input int last);
      for (int c = first; c <= last; c++) begin
         step();
         for (int s = 0; s < 3; s++) begin
            checks++;
            if ({cke[s], csbar[s], obs_word(s)} !== {1'b1, 1'b0, exp_word(s, c)}) begin
               errors++;
               $display("FAIL schedule inst%0d cycle %0d: got %h expected %h", s, cyc,
                        {cke[s], csbar[s], obs_word(s)}, {1'b1, 1'b0, exp_word(s, c)});
            end
            checks++;
            if (done[s] !== (c >= done_cycle(s))) begin
               errors++;
               $display("FAIL init_done inst%0d cycle %0d: got %b expected %b", s, cyc, done[s],
                        c >= done_cycle(s));
            end
            checks++;
            if ({odt[s], ts[s], ri[s]} !== 3'b000) begin
               errors++;
               $display("FAIL odt_ts_ri inst%0d cycle %0d: got %b expected 000", s, cyc,
                        {odt[s], ts[s], ri[s]});
            end
         end
      end
   endtask

   task automatic test_mid_reset();
      resetbar = 1'b0;
      release_reset();
      for (int c = 0; c <= 30; c++) step();
      #2;
      resetbar = 1'b0;
      #1;
      for (int s = 0; s < 3; s++) begin
         checks++;
         if ({cke[s], obs_word(s), done[s]} !== {1'b0, 3'b111, 2'b00, 13'h0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset inst%0d: got %h expected %h", s,
                     {cke[s], obs_word(s), done[s]}, {1'b0, 3'b111, 2'b00, 13'h0, 1'b0});
         end
      end
      release_reset();
      test_power_up();
      test_command_schedule(17, 66);
   endtask

   task automatic test_done_hold();
      for (int c = 0; c < 1000; c++) begin
         step();
         for (int s = 0; s < 3; s++) begin
            checks++;
            if ({done[s], cke[s], csbar[s], obs_word(s), odt[s], ts[s], ri[s]} !==
                {1'b1, 1'b1, 1'b0, 3'b111, 2'b00, 13'h0, 3'b000}) begin
               errors++;
               $display("FAIL done_hold inst%0d cycle %0d: got %h", s, cyc,
                        {done[s], cke[s], csbar[s], obs_word(s), odt[s], ts[s], ri[s]});
            end
         end
      end
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      cyc      = -1;
      resetbar = 1'b0;
      test_reset();
      test_power_up();
      test_command_schedule(17, 66);
      test_mid_reset();
      test_done_hold();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
